// File: rtl/result_bus_arbiter_pkg.sv
// Shared flat-array helpers, default parameters and configuration checks for result_bus_arbiter.
// Compile this file first: the macros below are used by the other files.
`ifndef RESULT_BUS_ARBITER_MACROS
`define RESULT_BUS_ARBITER_MACROS
`define FLAT_ARRAY(width, count) logic [((width)*(count))-1:0]
`define ARRAY(name, width, count) logic [(width)-1:0] name [(count)]
`define NORMAL_EQUALS_FLAT(label, normal, flat, width, count) \
    for (genvar gi = 0; gi < (count); gi++) begin : label \
        assign normal[gi] = flat[gi*(width) +: (width)]; \
    end
`endif

package result_bus_arbiter_pkg;

    localparam int DEFAULT_SIZE               = 32;
    localparam int DEFAULT_STATION_INDEX_SIZE = 2;
    localparam int DEFAULT_STATION_COUNT      = 4;
    localparam int DEFAULT_BUS_COUNT          = 1;

    // Every station tag must be representable in STATION_INDEX_SIZE bits.
    function automatic bit tags_fit(input int station_count, input int index_size);
        return station_count <= (1 << index_size);
    endfunction

endpackage

// File: rtl/result_bus_arbiter_rotating_priority_picker.sv
// Combinational picker: scans requests from a start index (wrapping) and hands the
// first PICK_COUNT requesters to picks 0..PICK_COUNT-1 in scan order.
module rotating_priority_picker #(
    parameter int REQUEST_COUNT = 4,
    parameter int INDEX_SIZE    = 2,
    parameter int PICK_COUNT    = 1
) (
    input  logic [REQUEST_COUNT-1:0]         request,
    input  logic [INDEX_SIZE-1:0]            start,
    output logic [REQUEST_COUNT-1:0]         grant,
    output logic [PICK_COUNT-1:0]            pick_valid,
    output logic [INDEX_SIZE*PICK_COUNT-1:0] pick_index,
    output logic [INDEX_SIZE-1:0]            last_index
);

    // rank = scan position of each station; prior = ready stations scanned before it.
    int rank  [REQUEST_COUNT];
    int prior [REQUEST_COUNT];

    always_comb begin
        int start_value;
        start_value = int'(start);
        for (int s = 0; s < REQUEST_COUNT; s++) begin
            rank[s] = (s >= start_value) ? (s - start_value) : (s + REQUEST_COUNT - start_value);
        end
        for (int s = 0; s < REQUEST_COUNT; s++) begin
            prior[s] = 0;
            for (int t = 0; t < REQUEST_COUNT; t++) begin
                if (request[t] && (rank[t] < rank[s])) begin
                    prior[s] = prior[s] + 1;
                end
            end
        end
    end

    always_comb begin
        int best_rank;
        grant      = '0;
        last_index = start;
        best_rank  = -1;
        for (int s = 0; s < REQUEST_COUNT; s++) begin
            if (request[s] && (prior[s] < PICK_COUNT)) begin
                grant[s] = 1'b1;
                if (rank[s] > best_rank) begin
                    best_rank  = rank[s];
                    last_index = INDEX_SIZE'(s);
                end
            end
        end
    end

    for (genvar gi = 0; gi < PICK_COUNT; gi++) begin : g_pick
        logic                  hit;
        logic [INDEX_SIZE-1:0] index;

        always_comb begin
            hit   = 1'b0;
            index = '0;
            for (int s = 0; s < REQUEST_COUNT; s++) begin
                if (request[s] && (prior[s] == gi)) begin
                    hit   = 1'b1;
                    index = INDEX_SIZE'(s);
                end
            end
        end

        assign pick_valid[gi]                              = hit;
        assign pick_index[gi*INDEX_SIZE +: INDEX_SIZE]     = index;
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// Result bus arbiter: grants up to BUS_COUNT ready stations per cycle onto registered result buses.
// RESULT_BUS_ROUND_ROBIN_EN selects a rotating start pointer; otherwise fixed priority (station 0 first, starvation possible).
module result_bus_arbiter
    import result_bus_arbiter_pkg::*;
#(
    parameter int SIZE               = DEFAULT_SIZE,
    parameter int STATION_INDEX_SIZE = DEFAULT_STATION_INDEX_SIZE,
    parameter int STATION_COUNT      = DEFAULT_STATION_COUNT,
    parameter int BUS_COUNT          = DEFAULT_BUS_COUNT
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [STATION_COUNT-1:0]                    station_ready,
    input  `FLAT_ARRAY(SIZE, STATION_COUNT)             station_result,
    output logic [STATION_COUNT-1:0]                    station_release,
    output logic [BUS_COUNT-1:0]                        bus_asserted,
    output `FLAT_ARRAY(STATION_INDEX_SIZE, BUS_COUNT)   bus_source,
    output `FLAT_ARRAY(SIZE, BUS_COUNT)                 bus_value
);

    localparam bit TAGS_FIT = tags_fit(STATION_COUNT, STATION_INDEX_SIZE);
    localparam int IW       = STATION_INDEX_SIZE;

    if (!TAGS_FIT || BUS_COUNT < 1 || BUS_COUNT > STATION_COUNT) begin : g_bad_configuration
        $error("result_bus_arbiter: station tags do not fit or BUS_COUNT out of range");
    end

    `ARRAY(results, SIZE, STATION_COUNT);
    `NORMAL_EQUALS_FLAT(g_unflatten_result, results, station_result, SIZE, STATION_COUNT)

    logic [IW-1:0]           scan_start;
    logic [STATION_COUNT-1:0] grant;
    logic [BUS_COUNT-1:0]    pick_valid;
    logic [IW*BUS_COUNT-1:0] pick_index;
    logic [IW-1:0]           last_index;

    rotating_priority_picker #(
        .REQUEST_COUNT (STATION_COUNT),
        .INDEX_SIZE    (IW),
        .PICK_COUNT    (BUS_COUNT)
    ) u_picker (
        .request    (station_ready),
        .start      (scan_start),
        .grant      (grant),
        .pick_valid (pick_valid),
        .pick_index (pick_index),
        .last_index (last_index)
    );

`ifdef RESULT_BUS_ROUND_ROBIN_EN
    logic [IW-1:0] pointer_reg;

    // Next scan starts just past the last station served this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            pointer_reg <= '0;
        end else if (|grant) begin
            pointer_reg <= (last_index == IW'(STATION_COUNT - 1)) ? '0 : last_index + IW'(1);
        end
    end

    assign scan_start = pointer_reg;
`else
    logic [IW-1:0] unused_last_index;

    assign unused_last_index = last_index;
    assign scan_start        = '0;
`endif

    // Grants raised while reset is high are discarded, so no station is released.
    assign station_release = reset ? '0 : grant;

    for (genvar gi = 0; gi < BUS_COUNT; gi++) begin : g_bus
        logic            asserted_reg;
        logic [IW-1:0]   source_reg;
        logic [SIZE-1:0] value_reg;
        logic [IW-1:0]   selected;

        assign selected = pick_index[gi*IW +: IW];

        always_ff @(posedge clock) begin
            if (reset) begin
                asserted_reg <= 1'b0;
                source_reg   <= '0;
                value_reg    <= '0;
            end else begin
                asserted_reg <= pick_valid[gi];
                if (pick_valid[gi]) begin
                    source_reg <= selected;
                    value_reg  <= results[selected];
                end
            end
        end

        assign bus_asserted[gi]                = asserted_reg;
        assign bus_source[gi*IW +: IW]         = source_reg;
        assign bus_value[gi*SIZE +: SIZE]      = value_reg;
    end

endmodule

// File: doc/result_bus_arbiter.md
Name: result_bus_arbiter

Overview:
- Sits directly downstream of the reservation stations (integer units and similar).
- Each cycle it selects up to BUS_COUNT stations with result_ready high and drives their results onto the registered result buses (bus_asserted / bus_source / bus_value).
- It pulses station_release back to each granted station's reset_occupied.
- The bus outputs feed the bus inputs of every station and the register-status logic.

Parameters:
- SIZE, 32, result width in bits.
- STATION_INDEX_SIZE, 2, width of a station tag; station s has tag s.
- STATION_COUNT, 4, number of requesting stations; must be ≤ 2^STATION_INDEX_SIZE.
- BUS_COUNT, 1, number of result buses driven per cycle; 1 ≤ BUS_COUNT ≤ STATION_COUNT.

Ports:
- clock  input  1  system clock
- reset  input  1  reset reset, synchronous, active-high; clock clock
- station_ready  input  STATION_COUNT  result_ready of each station, bit s = station s
- station_result  input  SIZE*STATION_COUNT  flat array of station results, slice s = station s
- station_release  output  STATION_COUNT  combinational grant; drives reset_occupied of station s
- bus_asserted  output  BUS_COUNT  flat array, registered bus-valid flags
- bus_source  output  STATION_INDEX_SIZE*BUS_COUNT  flat array, registered producing-station tag
- bus_value  output  SIZE*BUS_COUNT  flat array, registered result value

Behaviour:
- Reset:
  - bus_asserted = 0, bus_source = 0, bus_value = 0, priority pointer = 0.
  - station_release = 0 while reset is high.
- Grant selection (combinational):
  - Scan stations starting at the pointer, wrapping modulo STATION_COUNT.
  - The first ready station found goes to bus 0, the second to bus 1, and so on, up to BUS_COUNT grants.
  - station_release[s] = 1 exactly for granted stations, in the same cycle as the grant.
- Bus register update (clock edge):
  - Bus k loads asserted = 1, source = tag of its granted station, value = that station's result.
  - Buses with no grant load asserted = 0. source and value hold their previous values; they are don't-care when not asserted.
- Latency:
  - One cycle from grant to value on the bus.
  - The granted station clears occupied on the same edge, so it is not ready in the next cycle. No double grant is possible.
- Pointer update:
  - If any grant occurred, pointer <= (highest-scanned granted station + 1) mod STATION_COUNT.
  - With no grants, the pointer holds.
- Boundary conditions:
  - More ready stations than buses: the excess stations wait. Round-robin guarantees each waits at most ceil(STATION_COUNT/BUS_COUNT) - 1 grant cycles.
  - No ready stations: all bus_asserted deassert next cycle; no release.
  - Pointer at STATION_COUNT-1: the scan wraps to 0.
  - Reset asserted mid-operation: bus regs clear on that edge, pending grants are dropped, and station_release is forced to 0 that cycle.
- Dispatcher contract: the dispatcher must not set_occupied a station in a cycle where station_release for that station is 1.
- A station is never granted onto more than one bus in a cycle.

Optional Feature:
- Macro RESULT_BUS_ROUND_ROBIN_EN.
- Defined: round-robin pointer behaviour as above.
- Undefined:
  - Pointer register omitted; the scan always starts at station 0 (fixed priority, lowest index wins).
  - Starvation is permitted and documented.
  - All other timing is identical.

Decomposition:
- Shared package / include:
  - Existing FLAT_ARRAY / ARRAY / NORMAL_EQUALS_FLAT macros.
  - A localparam for the tag width check (STATION_COUNT ≤ 2^STATION_INDEX_SIZE).
- One natural sub-module, rotating_priority_picker:
  - Takes request vector, start pointer and BUS_COUNT.
  - Returns a grant vector and per-bus selected index.
  - Instantiated once, purely combinational.
- The top level holds the pointer and bus registers.

Test Plan:
- Reset held 2 cycles with station_ready = 4'b1111 -> station_release = 0, all bus outputs 0; after release, the first grant goes to station 0.
- STATION_COUNT=4, BUS_COUNT=1, only station 2 ready with result 0x0000_00AB -> release = 4'b0100 that cycle; next cycle bus_asserted=1, bus_source=2, bus_value=0xAB; station 2 no longer ready; the cycle after, bus_asserted=0.
- All 4 ready continuously (stations refilled after release), BUS_COUNT=1, round-robin on -> bus_source sequence 0,1,2,3,0; each station served exactly once per 4 cycles.
- BUS_COUNT=2, stations 1 and 3 ready, pointer=2 -> bus 0 gets station 3, bus 1 gets station 1; pointer becomes 2 (1+1 after wrap).
- Macro undefined, stations 0 and 3 ready continuously -> station 0 granted every cycle, station 3 never granted.
- Grant issued and reset asserted in the same cycle -> station_release=0, bus_asserted=0 after the edge, pointer=0.
